// File: rtl/sblk_act_feeder.sv
// Activation feeder: buffers an input word stream and answers each actbuf_wr_req window with cfg_words beats, cfg_blocks windows per layer.
// First beat comes one cycle after the word is pushed; input stalls on FIFO full or once the layer quota is accepted.

module sblk_act_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk_l,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_l) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module sblk_act_feeder #(
  parameter int ACT_W      = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic [CNT_W-1:0] cfg_blocks,
  input  logic             s_act_valid,
  input  logic [ACT_W-1:0] s_act_data,
  output logic             s_act_ready,
  input  logic             actbuf_wr_req,
  output logic             actbuf_wr_vld,
  output logic [ACT_W-1:0] actbuf_wr_data,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, WAIT_REQ, STREAM, WAIT_DROP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   words_q, blocks_q, word_cnt, blk_cnt;
  logic [2*CNT_W-1:0] in_cnt, total_q;
  logic               req_q, busy_q, done_q;
  logic               fifo_full, fifo_empty, push, pop;
  logic [ACT_W-1:0]   fifo_head;
  logic               start_ok, last_word, done_set;

  sblk_act_fifo #(.W(ACT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_l (clk_l),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s_act_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign start_ok    = cfg_start && (state == IDLE);
  assign s_act_ready = busy_q && !fifo_full && (in_cnt < total_q);
  assign push        = s_act_valid && s_act_ready;

  // Gating on the live request guarantees no beat lands outside an open update.
  assign actbuf_wr_vld  = (state == STREAM) && actbuf_wr_req && !fifo_empty;
  assign actbuf_wr_data = actbuf_wr_vld ? fifo_head : '0;
  assign pop            = actbuf_wr_vld;
  assign last_word      = (word_cnt == words_q - CNT_W'(1));

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      IDLE:      if (cfg_start) state_nxt = WAIT_REQ;
      WAIT_REQ:  if (actbuf_wr_req) state_nxt = STREAM;
      STREAM:    if (pop && last_word) state_nxt = WAIT_DROP;
      WAIT_DROP: begin
        // Registered request: the controller must have been seen low before re-arming.
        if (!req_q) begin
          if (blk_cnt == blocks_q) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_REQ;
          end
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      words_q  <= '0;
      blocks_q <= '0;
      total_q  <= '0;
      word_cnt <= '0;
      blk_cnt  <= '0;
      in_cnt   <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      req_q  <= actbuf_wr_req;
      done_q <= done_set;
      if (start_ok) begin
        words_q  <= cfg_words;
        blocks_q <= cfg_blocks;
        total_q  <= {{CNT_W{1'b0}}, cfg_words} * {{CNT_W{1'b0}}, cfg_blocks};
        word_cnt <= '0;
        blk_cnt  <= '0;
        in_cnt   <= '0;
        busy_q   <= 1'b1;
      end else begin
        if (done_set) busy_q <= 1'b0;
        if (push) in_cnt <= in_cnt + (2*CNT_W)'(1);
        if (pop) begin
          if (last_word) begin
            word_cnt <= '0;
            blk_cnt  <= blk_cnt + CNT_W'(1);
          end else begin
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
      end
    end
  end
endmodule
